// File: rtl/qif_syn_current_8b.sv
// Synaptic current stage feeding the QIF neuron: buffers presynaptic spike events,
// then on each tick applies exponential decay plus one event weight, saturated to 8 bits.
module qif_syn_current_8b #(
   parameter int DECAY_SHIFT = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int N_SYN       = 4,
   localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1,
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int CW = PW + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               ev_valid,
   input  logic [AW-1:0]      ev_addr,
   output logic               ev_ready,
   input  logic               w_we,
   input  logic [AW-1:0]      w_addr,
   input  logic signed [7:0]  w_data,
   input  logic               sat_clr,
   output logic signed [7:0]  I_syn,
   output logic [CW-1:0]      fifo_count,
   output logic               sat_flag
);

   logic signed [7:0] w_mem [N_SYN];
   logic [AW-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;

   logic              full, push, pop, ovf;
   logic signed [7:0] decay, head_w, i_nxt;
   logic signed [9:0] cur_ext, decay_ext, add_ext, sum;

   assign full     = (fifo_count == CW'(FIFO_DEPTH));
   assign ev_ready = !full;
   assign push     = ev_valid && ev_ready;
   assign pop      = tick && (fifo_count != '0);
   assign head_w   = w_mem[fifo_mem[rd_ptr]];

   // 10-bit sum cannot wrap: worst cases are 127-31+127 and -128+32-128.
   always_comb begin
      decay     = I_syn >>> DECAY_SHIFT;
      cur_ext   = {{2{I_syn[7]}}, I_syn};
      decay_ext = {{2{decay[7]}}, decay};
      add_ext   = pop ? {{2{head_w[7]}}, head_w} : '0;
      sum       = cur_ext - decay_ext + add_ext;
      ovf       = (sum[9:7] != 3'b000) && (sum[9:7] != 3'b111);
      i_nxt     = sum[7:0];
      if (ovf)
         i_nxt = sum[9] ? 8'sh80 : 8'sh7f;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         I_syn      <= '0;
         sat_flag   <= 1'b0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         for (int i = 0; i < N_SYN; i++)
            w_mem[i] <= '0;
      end else begin
         if (tick)
            I_syn <= i_nxt;

         if (tick && ovf)
            sat_flag <= 1'b1;
         else if (sat_clr)
            sat_flag <= 1'b0;

         if (w_we)
            w_mem[w_addr] <= w_data;

         if (push) begin
            fifo_mem[wr_ptr] <= ev_addr;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_qif_syn_current_8b.sv
// Randomized and directed bench for qif_syn_current_8b against a queue-based
// behavioural model of the synaptic current stage.
module tb_qif_syn_current_8b;

   localparam int DS    = 2;
   localparam int DEPTH = 4;
   localparam int NS    = 4;

   logic              clk = 1'b0;
   logic              reset, tick, ev_valid, w_we, sat_clr;
   logic [1:0]        ev_addr, w_addr;
   logic signed [7:0] w_data;
   logic              ev_ready, sat_flag;
   logic signed [7:0] I_syn;
   logic [2:0]        fifo_count;

   int errors = 0;
   int checks = 0;

   int m_i;
   bit m_sat;
   int m_w [NS];
   int q [$];

   qif_syn_current_8b #(.DECAY_SHIFT(DS), .FIFO_DEPTH(DEPTH), .N_SYN(NS)) dut (
      .clk(clk), .reset(reset), .tick(tick), .ev_valid(ev_valid), .ev_addr(ev_addr),
      .ev_ready(ev_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .sat_clr(sat_clr), .I_syn(I_syn), .fifo_count(fifo_count), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural reference: the stage's rules applied to a queue of pending events.
   task automatic model_edge();
      int nxt, add;
      bit can_take;
      if (reset) begin
         q.delete();
         m_i   = 0;
         m_sat = 0;
         foreach (m_w[k]) m_w[k] = 0;
         return;
      end
      can_take = (q.size() < DEPTH);
      if (tick) begin
         add = 0;
         if (q.size() > 0) begin
            add = m_w[q[0]];
            void'(q.pop_front());
         end
         nxt = m_i - (m_i >>> DS) + add;
         if (nxt > 127 || nxt < -128) begin
            m_sat = 1;
            nxt   = (nxt > 127) ? 127 : -128;
         end else if (sat_clr) begin
            m_sat = 0;
         end
         m_i = nxt;
      end else if (sat_clr) begin
         m_sat = 0;
      end
      if (ev_valid && can_take)
         q.push_back(int'(ev_addr));
      if (w_we)
         m_w[w_addr] = int'(w_data);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("I_syn", int'(I_syn), m_i);
      check("fifo_count", int'(fifo_count), q.size());
      check("ev_ready", int'(ev_ready), (q.size() < DEPTH) ? 1 : 0);
      check("sat_flag", int'(sat_flag), int'(m_sat));
   endtask

   task automatic idle();
      reset = 0; tick = 0; ev_valid = 0; ev_addr = 0;
      w_we = 0; w_addr = 0; w_data = 0; sat_clr = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      cycle();
      reset = 0;
   endtask

   task automatic write_w(input int a, input int d);
      idle();
      w_we = 1; w_addr = 2'(a); w_data = 8'(d);
      cycle();
      w_we = 0;
   endtask

   task automatic push_ev(input int a, input int n);
      idle();
      ev_valid = 1; ev_addr = 2'(a);
      repeat (n) cycle();
      ev_valid = 0;
   endtask

   int dec_seq [8] = '{40, 30, 23, 18, 14, 11, 9, 7};
   int neg_seq [3] = '{-96, -72, -54};

   initial begin
      idle();
      reset = 1;
      cycle();
      cycle();
      reset = 0;
      tick = 1;
      repeat (3) cycle();
      check("idle_I", int'(I_syn), 0);
      check("idle_ready", int'(ev_ready), 1);

      // decay of a single event
      write_w(1, 40);
      push_ev(1, 1);
      tick = 1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("decay_seq", int'(I_syn), dec_seq[k]);
         if (k == 0) check("decay_empty", int'(fifo_count), 0);
      end

      // full FIFO, positive saturation, sat_clr
      do_reset();
      write_w(0, 127);
      push_ev(0, 4);
      check("full_count", int'(fifo_count), 4);
      check("full_ready", int'(ev_ready), 0);
      push_ev(0, 1);
      check("full_ignored", int'(fifo_count), 4);
      tick = 1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("pos_sat_I", int'(I_syn), 127);
         if (k == 0) check("pos_sat_flag0", int'(sat_flag), 0);
         if (k == 1) check("pos_sat_flag1", int'(sat_flag), 1);
      end
      idle();
      sat_clr = 1;
      cycle();
      check("sat_clr", int'(sat_flag), 0);

      // negative saturation and decay toward zero
      do_reset();
      write_w(2, -128);
      push_ev(2, 2);
      tick = 1;
      cycle();
      check("neg_I0", int'(I_syn), -128);
      cycle();
      check("neg_I1", int'(I_syn), -128);
      check("neg_flag", int'(sat_flag), 1);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("neg_decay", int'(I_syn), neg_seq[k]);
      end

      // simultaneous push+pop with a same-cycle write to the head's weight
      do_reset();
      write_w(3, 20);
      write_w(1, 10);
      push_ev(3, 1);
      push_ev(1, 2);
      idle();
      tick = 1; ev_valid = 1; ev_addr = 1;
      w_we = 1; w_addr = 3; w_data = 99;
      cycle();
      check("pushpop_count", int'(fifo_count), 3);
      check("pushpop_oldw", int'(I_syn), 20);

      // reset mid-operation flushes everything
      do_reset();
      write_w(0, 50);
      push_ev(0, 1);
      idle(); tick = 1;
      cycle();
      push_ev(2, 3);
      check("pre_rst_I", int'(I_syn), 50);
      check("pre_rst_cnt", int'(fifo_count), 3);
      do_reset();
      check("rst_I", int'(I_syn), 0);
      check("rst_cnt", int'(fifo_count), 0);
      check("rst_ready", int'(ev_ready), 1);
      idle(); tick = 1;
      cycle();
      check("rst_tick_I", int'(I_syn), 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom_range(0, 249) == 0);
         tick     = ($urandom_range(0, 9) < 3);
         ev_valid = ($urandom_range(0, 1) == 1);
         ev_addr  = 2'($urandom_range(0, NS - 1));
         w_we     = ($urandom_range(0, 9) == 0);
         w_addr   = 2'($urandom_range(0, NS - 1));
         w_data   = 8'($urandom);
         sat_clr  = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
